// File: rtl/sdram_arbit_pkg.sv
// Shared constants and state encoding for the SDRAM command arbiter.
package sdram_arbit_pkg;

   localparam logic [3:0] CMD_NOP = 4'b0111;

   localparam int ARB_MODE_FIXED = 0;
   localparam int ARB_MODE_RR    = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARB  = 2'd1,
      CH   = 2'd2,
      AR   = 2'd3
   } arb_state_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/sdram_rr_pick.sv
// Combinational channel picker: fixed priority or round-robin from ptr+1.
module sdram_rr_pick
   import sdram_arbit_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int ID_W   = 1
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [ID_W-1:0]   ptr,
   input  logic              mode,
   output logic              vld,
   output logic [ID_W-1:0]   idx
);

   int c;

   // Scan from lowest priority to highest so the last hit wins.
   always_comb begin
      vld = |req;
      idx = '0;
      c   = 0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         c = mode ? ((int'(ptr) + 1 + i) % NUM_CH) : i;
         if (req[c]) idx = ID_W'(c);
      end
   end

endmodule

// File: rtl/sdram_arbit_rr.sv
// SDRAM command arbiter: init, refresh (highest priority) and NUM_CH channels
// onto one registered command/address/DQ bus, with an ownership watchdog.
module sdram_arbit_rr
   import sdram_arbit_pkg::*;
#(
   parameter int NUM_CH   = 2,
   parameter int ADDR_W   = 13,
   parameter int BANK_W   = 2,
   parameter int DQ_W     = 16,
   parameter int ARB_MODE = ARB_MODE_RR,
   parameter int TIMEOUT  = 1023,
   localparam int ID_W    = (NUM_CH > 1) ? clog2(NUM_CH) : 1
) (
   input  logic                     arb_clk,
   input  logic                     arb_rst,
   input  logic                     init_end,
   input  logic [3:0]               init_cmd,
   input  logic [BANK_W-1:0]        init_bank,
   input  logic [ADDR_W-1:0]        init_addr,
   input  logic                     ar_req,
   input  logic                     ar_end,
   input  logic [3:0]               ar_cmd,
   input  logic [BANK_W-1:0]        ar_bank,
   input  logic [ADDR_W-1:0]        ar_addr,
   output logic                     ar_en,
   input  logic [NUM_CH-1:0]        ch_req,
   input  logic [NUM_CH-1:0]        ch_end,
   input  logic [4*NUM_CH-1:0]      ch_cmd,
   input  logic [BANK_W*NUM_CH-1:0] ch_bank,
   input  logic [ADDR_W*NUM_CH-1:0] ch_addr,
   input  logic [NUM_CH-1:0]        ch_dq_oe,
   input  logic [DQ_W*NUM_CH-1:0]   ch_dq_wdata,
   output logic [NUM_CH-1:0]        ch_en,
   output logic [ID_W-1:0]          grant_id,
   output logic                     err_timeout,
   output logic                     sdram_cke,
   output logic                     sdram_cs_n,
   output logic                     sdram_ras_n,
   output logic                     sdram_cas_n,
   output logic                     sdram_we_n,
   output logic [BANK_W-1:0]        sdram_bank,
   output logic [ADDR_W-1:0]        sdram_addr,
   output logic [DQ_W-1:0]          sdram_dq_out,
   output logic                     sdram_dq_oe
);

   localparam int CNT_W = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic [NUM_CH-1:0][3:0]        cmd_a;
   logic [NUM_CH-1:0][BANK_W-1:0] bank_a;
   logic [NUM_CH-1:0][ADDR_W-1:0] addr_a;
   logic [NUM_CH-1:0][DQ_W-1:0]   dq_a;

   assign cmd_a  = ch_cmd;
   assign bank_a = ch_bank;
   assign addr_a = ch_addr;
   assign dq_a   = ch_dq_wdata;

   arb_state_e        state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ar_en_d, err_d;
   logic [NUM_CH-1:0] ch_en_d;
   logic [ID_W-1:0]   gid_d;
   logic              pick_vld;
   logic [ID_W-1:0]   pick_idx;
   logic              wd_fire;

   logic [3:0]        mux_cmd;
   logic [BANK_W-1:0] mux_bank;
   logic [ADDR_W-1:0] mux_addr;
   logic              mux_oe;
   logic [3:0]        cmd_q;

   sdram_rr_pick #(.NUM_CH(NUM_CH), .ID_W(ID_W)) u_pick (
      .req  (ch_req),
      .ptr  (ptr_q),
      .mode (ARB_MODE == ARB_MODE_RR),
      .vld  (pick_vld),
      .idx  (pick_idx)
   );

   // An end seen in the same cycle as the last watchdog count takes precedence.
   assign wd_fire = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

   always_comb begin
      state_d  = state_q;
      ar_en_d  = ar_en;
      ch_en_d  = ch_en;
      gid_d    = grant_id;
      ptr_d    = ptr_q;
      err_d    = 1'b0;
      cnt_d    = '0;
      mux_cmd  = CMD_NOP;
      mux_bank = '1;
      mux_addr = '1;
      mux_oe   = 1'b0;
      case (state_q)
         IDLE: begin
            mux_cmd  = init_cmd;
            mux_bank = init_bank;
            mux_addr = init_addr;
            if (init_end) state_d = ARB;
         end
         ARB: begin
            if (ar_req) begin
               state_d = AR;
               ar_en_d = 1'b1;
            end else if (pick_vld) begin
               state_d = CH;
               ch_en_d = NUM_CH'(1) << pick_idx;
               gid_d   = pick_idx;
               ptr_d   = pick_idx;
            end
         end
         AR: begin
            mux_cmd  = ar_cmd;
            mux_bank = ar_bank;
            mux_addr = ar_addr;
            cnt_d    = cnt_q + CNT_W'(1);
            if (ar_end || wd_fire) begin
               state_d = ARB;
               ar_en_d = 1'b0;
               err_d   = !ar_end;
            end
         end
         CH: begin
            mux_cmd  = cmd_a[grant_id];
            mux_bank = bank_a[grant_id];
            mux_addr = addr_a[grant_id];
            mux_oe   = ch_dq_oe[grant_id];
            cnt_d    = cnt_q + CNT_W'(1);
            if (ch_end[grant_id] || wd_fire) begin
               state_d = ARB;
               ch_en_d = '0;
               err_d   = !ch_end[grant_id];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge arb_clk) begin
      if (arb_rst) begin
         state_q      <= IDLE;
         ar_en        <= 1'b0;
         ch_en        <= '0;
         grant_id     <= '0;
         err_timeout  <= 1'b0;
         ptr_q        <= ID_W'(NUM_CH - 1);
         cnt_q        <= '0;
         cmd_q        <= CMD_NOP;
         sdram_bank   <= '1;
         sdram_addr   <= '1;
         sdram_dq_out <= '0;
         sdram_dq_oe  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ar_en       <= ar_en_d;
         ch_en       <= ch_en_d;
         grant_id    <= gid_d;
         err_timeout <= err_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         cmd_q       <= mux_cmd;
         sdram_bank  <= mux_bank;
         sdram_addr  <= mux_addr;
         sdram_dq_oe <= mux_oe;
         if (mux_oe) sdram_dq_out <= dq_a[grant_id];
      end
   end

   assign sdram_cke = 1'b1;
   assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_q;

endmodule

// File: tb/tb_sdram_arbit_rr.sv
// Bench: fixed-priority and round-robin arbiters driven in parallel and
// compared every cycle against an ownership-level reference model.
module tb_sdram_arbit_rr;

   localparam int N  = 3;
   localparam int AW = 13;
   localparam int BW = 2;
   localparam int DW = 16;
   localparam int TO = 8;

   localparam int OWN_INIT = -3;
   localparam int OWN_REF  = -2;
   localparam int OWN_FREE = -1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic              init_end;
   logic [3:0]        init_cmd;
   logic [BW-1:0]     init_bank;
   logic [AW-1:0]     init_addr;
   logic              ar_req, ar_end;
   logic [3:0]        ar_cmd;
   logic [BW-1:0]     ar_bank;
   logic [AW-1:0]     ar_addr;
   logic [N-1:0]      ch_req, ch_end, ch_dq_oe;
   logic [4*N-1:0]    ch_cmd;
   logic [BW*N-1:0]   ch_bank;
   logic [AW*N-1:0]   ch_addr;
   logic [DW*N-1:0]   ch_dq_wdata;

   logic          o_ar_en [2];
   logic [N-1:0]  o_ch_en [2];
   logic [1:0]    o_gid   [2];
   logic          o_err   [2];
   logic          o_cke   [2];
   logic          o_cs [2], o_ras [2], o_cas [2], o_we [2];
   logic [BW-1:0] o_bank  [2];
   logic [AW-1:0] o_addr  [2];
   logic [DW-1:0] o_dq    [2];
   logic          o_oe    [2];

   for (genvar m = 0; m < 2; m++) begin : g_dut
      sdram_arbit_rr #(
         .NUM_CH(N), .ADDR_W(AW), .BANK_W(BW), .DQ_W(DW),
         .ARB_MODE(m), .TIMEOUT(TO)
      ) u_dut (
         .arb_clk(clk), .arb_rst(rst),
         .init_end(init_end), .init_cmd(init_cmd), .init_bank(init_bank), .init_addr(init_addr),
         .ar_req(ar_req), .ar_end(ar_end), .ar_cmd(ar_cmd), .ar_bank(ar_bank), .ar_addr(ar_addr),
         .ar_en(o_ar_en[m]),
         .ch_req(ch_req), .ch_end(ch_end), .ch_cmd(ch_cmd), .ch_bank(ch_bank), .ch_addr(ch_addr),
         .ch_dq_oe(ch_dq_oe), .ch_dq_wdata(ch_dq_wdata),
         .ch_en(o_ch_en[m]), .grant_id(o_gid[m]), .err_timeout(o_err[m]),
         .sdram_cke(o_cke[m]), .sdram_cs_n(o_cs[m]), .sdram_ras_n(o_ras[m]),
         .sdram_cas_n(o_cas[m]), .sdram_we_n(o_we[m]),
         .sdram_bank(o_bank[m]), .sdram_addr(o_addr[m]),
         .sdram_dq_out(o_dq[m]), .sdram_dq_oe(o_oe[m])
      );
   end

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   // Reference model, index 0 = fixed priority, 1 = round-robin.
   int            own [2], gid [2], ptr [2], held [2];
   logic          m_err [2], m_oe [2];
   logic [3:0]    m_cmd [2];
   logic [BW-1:0] m_bank [2];
   logic [AW-1:0] m_addr [2];
   logic [DW-1:0] m_dq [2];

   int            q0 [$], q1 [$];
   int            errcnt [2];
   logic [N-1:0]  prev_en [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input int m, input logic [N-1:0] req, input int p);
      int r, c;
      r = -1;
      for (int o = 0; o < N; o++) begin
         c = (m == 1) ? (p + 1 + o) % N : o;
         if (r < 0 && req[c]) r = c;
      end
      return r;
   endfunction

   task automatic model_step(input int m);
      int   k;
      logic done;
      if (rst) begin
         own[m] = OWN_INIT; gid[m] = 0; ptr[m] = N - 1; held[m] = 0;
         m_err[m] = 1'b0; m_cmd[m] = 4'b0111; m_bank[m] = '1; m_addr[m] = '1;
         m_dq[m] = '0; m_oe[m] = 1'b0;
         return;
      end
      m_err[m] = 1'b0;
      m_oe[m]  = 1'b0;
      case (own[m])
         OWN_INIT: begin m_cmd[m] = init_cmd; m_bank[m] = init_bank; m_addr[m] = init_addr; end
         OWN_FREE: begin m_cmd[m] = 4'b0111; m_bank[m] = '1; m_addr[m] = '1; end
         OWN_REF:  begin m_cmd[m] = ar_cmd; m_bank[m] = ar_bank; m_addr[m] = ar_addr; end
         default: begin
            k = own[m];
            m_cmd[m]  = ch_cmd[4*k +: 4];
            m_bank[m] = ch_bank[BW*k +: BW];
            m_addr[m] = ch_addr[AW*k +: AW];
            m_oe[m]   = ch_dq_oe[k];
            if (ch_dq_oe[k]) m_dq[m] = ch_dq_wdata[DW*k +: DW];
         end
      endcase
      if (own[m] == OWN_INIT) begin
         if (init_end) own[m] = OWN_FREE;
      end else if (own[m] == OWN_FREE) begin
         if (ar_req) begin
            own[m] = OWN_REF; held[m] = 0;
         end else begin
            k = pick(m, ch_req, ptr[m]);
            if (k >= 0) begin own[m] = k; gid[m] = k; ptr[m] = k; held[m] = 0; end
         end
      end else begin
         done = (own[m] == OWN_REF) ? ar_end : ch_end[own[m]];
         if (done) own[m] = OWN_FREE;
         else begin
            held[m]++;
            if (held[m] == TO) begin own[m] = OWN_FREE; m_err[m] = 1'b1; end
         end
      end
   endtask

   task automatic tick();
      logic [N-1:0] eh;
      string        p;
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      cyc++;
      for (int m = 0; m < 2; m++) begin
         p  = (m == 0) ? "fp" : "rr";
         eh = (own[m] >= 0) ? N'(1) << own[m] : '0;
         chk({p, ".ch_en"}, 32'(o_ch_en[m]), 32'(eh));
         chk({p, ".ar_en"}, 32'(o_ar_en[m]), 32'(own[m] == OWN_REF));
         chk({p, ".grant_id"}, 32'(o_gid[m]), 32'(gid[m]));
         chk({p, ".err"}, 32'(o_err[m]), 32'(m_err[m]));
         chk({p, ".cke"}, 32'(o_cke[m]), 32'd1);
         chk({p, ".cmd"}, 32'({o_cs[m], o_ras[m], o_cas[m], o_we[m]}), 32'(m_cmd[m]));
         chk({p, ".bank"}, 32'(o_bank[m]), 32'(m_bank[m]));
         chk({p, ".addr"}, 32'(o_addr[m]), 32'(m_addr[m]));
         chk({p, ".dq_oe"}, 32'(o_oe[m]), 32'(m_oe[m]));
         chk({p, ".dq_out"}, 32'(o_dq[m]), 32'(m_dq[m]));
         if (prev_en[m] == '0 && o_ch_en[m] != '0)
            for (int i = 0; i < N; i++)
               if (o_ch_en[m][i]) begin
                  if (m == 0) q0.push_back(i); else q1.push_back(i);
               end
         if (o_err[m]) errcnt[m]++;
         prev_en[m] = o_ch_en[m];
      end
   endtask

   task automatic drain();
      ch_req = '0; ar_req = 1'b0; ch_end = '1; ar_end = 1'b1;
      repeat (2) tick();
      ch_end = '0; ar_end = 1'b0;
      tick();
   endtask

   task automatic rand_data();
      init_cmd  = 4'($urandom);  init_bank = BW'($urandom); init_addr = AW'($urandom);
      ar_cmd    = 4'($urandom);  ar_bank   = BW'($urandom); ar_addr   = AW'($urandom);
      ch_cmd    = (4*N)'($urandom);
      ch_bank   = (BW*N)'($urandom);
      ch_addr   = (AW*N)'({$urandom(), $urandom()});
      ch_dq_wdata = (DW*N)'({$urandom(), $urandom()});
   endtask

   initial begin
      logic [3:0] drv_cmd;
      int   t_drop, t_ar, t_grant, t_err, t_fall;
      logic ref_seen;

      prev_en[0] = '0; prev_en[1] = '0; errcnt[0] = 0; errcnt[1] = 0;
      rst = 1'b1; init_end = 1'b0; ar_req = 1'b0; ar_end = 1'b0;
      ch_req = '0; ch_end = '0; ch_dq_oe = '0;
      rand_data();
      repeat (3) tick();

      // Init phase: init_* passes through until init_end, then NOP.
      rst = 1'b0;
      drv_cmd = 4'h0;
      for (int i = 0; i < 9; i++) begin
         rand_data();
         drv_cmd  = init_cmd;
         init_end = (i == 5);
         tick();
         if (i == 5) chk("init.cmd_lag", 32'({o_cs[1], o_ras[1], o_cas[1], o_we[1]}), 32'(drv_cmd));
         if (i == 7) chk("init.nop", 32'({o_cs[1], o_ras[1], o_cas[1], o_we[1]}), 32'h7);
      end
      init_end = 1'b0;

      // All channels requesting, each owner ends on its 4th cycle.
      q0.delete(); q1.delete();
      ch_req = '1;
      for (int i = 0; i < 30; i++) begin
         ch_end = (own[1] >= 0 && held[1] == 3) ? '1 : '0;
         tick();
      end
      drain();
      chk("rr.ngrants", 32'(q1.size() >= 5), 32'd1);
      chk("fp.ngrants", 32'(q0.size()), 32'(q1.size()));
      if (q1.size() >= 5) begin
         chk("rr.order0", 32'(q1[0]), 32'd0);
         chk("rr.order1", 32'(q1[1]), 32'd1);
         chk("rr.order2", 32'(q1[2]), 32'd2);
         chk("rr.order3", 32'(q1[3]), 32'd0);
         chk("rr.order4", 32'(q1[4]), 32'd1);
      end
      foreach (q0[i]) chk("fp.always0", 32'(q0[i]), 32'd0);

      // Refresh raised while channel 1 owns: waits for the end, then wins ARB.
      q0.delete(); q1.delete();
      ref_seen = 1'b0; t_drop = -100; t_ar = -50;
      ch_req = 3'b010;
      for (int i = 0; i < 24; i++) begin
         ar_req = (i >= 2) && !ref_seen;
         ch_req = ref_seen ? 3'b111 : 3'b010;
         ch_end = (own[1] >= 0 && held[1] == 4) ? '1 : '0;
         ar_end = (own[1] == OWN_REF && held[1] == 2);
         tick();
         if (own[1] == OWN_REF) ref_seen = 1'b1;
         if (prev_en[1] == '0 && t_drop < 0 && q1.size() == 1) t_drop = cyc;
         if (o_ar_en[1] && t_ar < 0) t_ar = cyc;
      end
      drain();
      chk("ref.granted", 32'(ref_seen), 32'd1);
      chk("ref.one_arb_gap", 32'(t_ar - t_drop), 32'd1);
      chk("ref.first_ch", 32'(q1.size() >= 2 ? q1[0] : -1), 32'd1);
      chk("ref.ptr_kept", 32'(q1.size() >= 2 ? q1[1] : -1), 32'd2);

      // Watchdog: no end on the first grant, then end exactly at the limit.
      q0.delete(); q1.delete();
      errcnt[0] = 0; errcnt[1] = 0;
      t_grant = -100; t_err = -50; t_fall = -25;
      ch_req = 3'b011; ch_end = '0;
      for (int i = 0; i < 11; i++) begin
         tick();
         if (q1.size() == 1 && t_grant < 0) t_grant = cyc;
         if (o_err[1] && t_err < 0) t_err = cyc;
         if (q1.size() == 1 && o_ch_en[1] == '0 && t_fall < 0) t_fall = cyc;
      end
      chk("wd.err_delay", 32'(t_err - t_grant), 32'(TO));
      chk("wd.drop_with_err", 32'(t_fall), 32'(t_err));
      chk("wd.err_count", 32'(errcnt[1]), 32'd1);
      chk("wd.next_ch", 32'(q1.size() >= 2 ? q1[1] : -1), 32'd1);
      errcnt[0] = 0; errcnt[1] = 0;
      ch_req = '0;
      for (int i = 0; i < 12; i++) begin
         ch_end = (own[1] >= 0 && held[1] == TO - 1) ? '1 : '0;
         tick();
      end
      chk("wd.end_wins_rr", 32'(errcnt[1]), 32'd0);
      chk("wd.end_wins_fp", 32'(errcnt[0]), 32'd0);
      chk("wd.released", 32'(o_ch_en[1]), 32'd0);
      drain();

      // DQ path from channel 1, then reset in the middle of the grant.
      rand_data();
      ch_dq_wdata[DW +: DW] = 16'hA5A5;
      ch_dq_oe = 3'b010; ch_req = 3'b010;
      repeat (3) tick();
      chk("dq.oe", 32'(o_oe[1]), 32'd1);
      chk("dq.data", 32'(o_dq[1]), 32'hA5A5);
      rst = 1'b1;
      tick();
      for (int m = 0; m < 2; m++) begin
         chk("rst.ch_en", 32'(o_ch_en[m]), 32'd0);
         chk("rst.ar_en", 32'(o_ar_en[m]), 32'd0);
         chk("rst.cmd", 32'({o_cs[m], o_ras[m], o_cas[m], o_we[m]}), 32'h7);
         chk("rst.dq_oe", 32'(o_oe[m]), 32'd0);
      end
      rst = 1'b0; ch_req = '0; ch_dq_oe = '0;
      init_cmd = 4'b0010;
      tick();
      chk("rst.idle_init", 32'({o_cs[1], o_ras[1], o_cas[1], o_we[1]}), 32'h2);

      // Random traffic including refresh, timeouts and occasional reset.
      for (int i = 0; i < 700; i++) begin
         rand_data();
         rst      = ($urandom_range(0, 199) == 0);
         init_end = ($urandom_range(0, 5) == 0);
         ar_req   = ($urandom_range(0, 9) == 0);
         ar_end   = ($urandom_range(0, 3) == 0);
         ch_req   = N'($urandom);
         ch_end   = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
         ch_dq_oe = N'($urandom);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/sdram_arbit_rr.md
Name: sdram_arbit_rr

Overview:
Parametrised successor to the SDRAM command arbiter. It multiplexes init, auto-refresh and NUM_CH generic requesters (write/read ports, DMA and so on) onto one SDRAM command/address/DQ bus. Refresh always has highest priority. Channel selection is either fixed-priority or round-robin, and a watchdog reclaims the bus from a hung owner. Command, bank, address and DQ outputs are registered, adding one cycle of latency. The block sits between the per-function SDRAM sub-controllers and the pad-level tristate.

Parameters:
NUM_CH, 2, number of generic requester channels (1..8)
ADDR_W, 13, SDRAM address width
BANK_W, 2, SDRAM bank width
DQ_W, 16, SDRAM data width
ARB_MODE, 1, 0 = fixed priority (channel 0 highest), 1 = round-robin
TIMEOUT, 1023, maximum cycles a grant may be held without a matching end; 0 disables the watchdog

Ports:
arb_clk  in  1  clock
arb_rst  in  1  synchronous active-high reset
init_end  in  1  init sequence complete
init_cmd  in  4  init command {cs_n,ras_n,cas_n,we_n}
init_bank  in  BANK_W  init bank
init_addr  in  ADDR_W  init address
ar_req  in  1  refresh request
ar_end  in  1  refresh done
ar_cmd  in  4  refresh command
ar_bank  in  BANK_W  refresh bank
ar_addr  in  ADDR_W  refresh address
ar_en  out  1  refresh granted
ch_req  in  NUM_CH  channel requests
ch_end  in  NUM_CH  channel done
ch_cmd  in  4*NUM_CH  per-channel command, channel i at bits [4i+3:4i]
ch_bank  in  BANK_W*NUM_CH  per-channel bank
ch_addr  in  ADDR_W*NUM_CH  per-channel address
ch_dq_oe  in  NUM_CH  per-channel DQ drive enable
ch_dq_wdata  in  DQ_W*NUM_CH  per-channel write data
ch_en  out  NUM_CH  one-hot channel grant
grant_id  out  clog2(NUM_CH)  index of the current or last granted channel
err_timeout  out  1  one-cycle pulse when the watchdog fires
sdram_cke  out  1  constant 1
sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1 each  registered command
sdram_bank  out  BANK_W  registered bank
sdram_addr  out  ADDR_W  registered address
sdram_dq_out  out  DQ_W  registered write data
sdram_dq_oe  out  1  registered DQ output enable; tristate is done at top level

Behaviour:
- All flops use synchronous reset on arb_rst (active-high).
- Reset values:
  - state = IDLE
  - ar_en = 0, ch_en = 0, grant_id = 0, err_timeout = 0
  - command = NOP (4'b0111), bank = all ones, addr = all ones
  - dq_out = 0, dq_oe = 0
  - round-robin pointer = NUM_CH-1, so channel 0 is searched first
- Reset asserted mid-transaction aborts the owner immediately; there is no end handshake.
- States: IDLE, ARB, AR, CH.
  - IDLE: output mux selects init_*. Moves to ARB on init_end. After leaving IDLE, init_end is ignored until reset.
  - ARB: output mux selects NOP / all-ones.
    - If ar_req: go to AR and set ar_en.
    - Else if any ch_req: go to CH, set ch_en[k] and grant_id = k, where k is the picked channel.
    - Else stay in ARB.
    - The grant takes effect on the clock edge that leaves ARB.
  - AR: output mux selects ar_*. On ar_end, clear ar_en and return to ARB.
  - CH: output mux selects channel grant_id. On ch_end[grant_id], clear ch_en and return to ARB. ch_end on non-owner channels is ignored.
- Channel pick:
  - ARB_MODE = 0: lowest-index requester wins.
  - ARB_MODE = 1: first requester found searching from pointer+1 upward, wrapping modulo NUM_CH. The pointer updates to k only when a channel grant is issued; refresh grants do not move it.
- At least one ARB cycle (NOP) separates consecutive owners. An end and a new request in the same cycle are therefore serviced one cycle later.
- Refresh cannot preempt an active channel. ar_req raised during CH is granted at the next ARB cycle, ahead of all channels.
- Output register: the mux result is registered every cycle, so sdram_* lags the selected source by exactly 1 cycle.
  - sdram_dq_oe = registered (state == CH) & ch_dq_oe[grant_id].
  - sdram_dq_out = registered ch_dq_wdata of grant_id. It holds its value when oe = 0.
- Watchdog (TIMEOUT > 0):
  - The counter clears on entry to AR or CH and increments each cycle in those states.
  - If the counter reaches TIMEOUT with no end seen: clear the en, pulse err_timeout for 1 cycle, go to ARB.
  - If an end arrives in the same cycle the counter reaches TIMEOUT, the end wins and there is no error.
  - Counter width is clog2(TIMEOUT+1).
- grant_id holds its value when no channel is owned.

Decomposition:
- Package sdram_arbit_pkg holds CMD_NOP, the state encodings (IDLE = 0, ARB = 1, AR = 3, CH = 2), the ARB_MODE_FIXED / ARB_MODE_RR constants, and a clog2 function.
- One sub-module, sdram_rr_pick: combinational. Inputs are the request vector, pointer and mode; outputs are a valid flag and the picked index. Instantiated once.

Test Plan:
- Reset, then init_end = 1 at cycle 5 → while in IDLE, sdram_* follows init_* with 1-cycle lag; state is ARB at cycle 6 and the command is NOP from cycle 7.
- ARB_MODE = 1, NUM_CH = 3, ch_req = 3'b111 held, each owner pulses end 4 cycles after grant → grant order 0, 1, 2, 0, 1, with exactly one NOP cycle between owners.
- ARB_MODE = 0, same stimulus → channel 0 granted every time; channels 1 and 2 never granted.
- ar_req raised while channel 1 owns the bus → ch_en held until ch_end[1]; ar_en = 1 one ARB cycle later; the RR pointer is unchanged after the refresh completes.
- TIMEOUT = 8, grant channel 0 and never assert ch_end → ch_en[0] drops and err_timeout pulses on the 8th cycle after grant; channel 1 is served next. Also check: end in the same cycle the counter reaches TIMEOUT → no error pulse.
- ch_dq_oe[1] = 1, ch_dq_wdata[1] = 16'hA5A5 during CH(1) → sdram_dq_oe = 1 and dq_out = 16'hA5A5 one cycle later. Assert arb_rst mid-grant → the next cycle shows all en = 0, NOP, dq_oe = 0, state IDLE.
